fixed_mac_pipe: RTL
===================

Name: fixed_mac_pipe

Overview:
Pipelined, multi-lane, saturating fixed-point multiply-accumulate for the LSTM gate datapath. Each accepted beat holds LANES signed Q(WIDTH-FRAC_BITS).FRAC_BITS operand pairs. The lane products are summed and accumulated across beats until a beat flagged `last` is accepted; the dot product is then rescaled, optionally rounded, saturated to WIDTH and emitted. It replaces the single combinational saturating multiply in gate/cell-state dot products and adds valid/ready flow control.

Parameters:
WIDTH, 16, operand and result width (signed).
FRAC_BITS, 8, fractional bits of operands and result; must be 1..WIDTH-1.
LANES, 4, products per beat; must be >= 1.
ACC_WIDTH, 40, internal accumulator width; must be >= 2*WIDTH + clog2(LANES).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_a  in  LANES*WIDTH  packed signed operands; lane i is bits [i*WIDTH +: WIDTH].
in_b  in  LANES*WIDTH  packed signed operands, same packing.
in_last  in  1  final beat of the current vector.
round_en  in  1  result rounding mode; sampled only on the accepted last beat. 1 = round half up, 0 = truncate toward minus infinity.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_sum  out  WIDTH  saturated signed dot product.
out_overflow  out  1  saturation occurred anywhere in this vector.
busy  out  1  any pipeline stage or the accumulator holds data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_sum=0, out_overflow=0, busy=0. All stage valids, the accumulator and the sticky flag are cleared.
- A reset asserted mid-vector discards all partial state. in_ready=1 in the first cycle after rst_n deasserts.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - All stages move only when advance=1; otherwise every register holds.
  - out_sum and out_overflow stay stable while out_valid=1 and out_ready=0.
- S1, products: per lane, a full 2*WIDTH signed product is registered. Valid, last and round_en are carried along.
- S2, lane sum and accumulate:
  - Lane products are sign-extended to ACC_WIDTH and summed.
  - If the accumulator is empty (after reset or after a last), acc loads the sum; otherwise acc = acc + sum.
  - If the addition leaves the ACC_WIDTH signed range, acc clamps to the max/min and the sticky flag is set.
- S3, output, on the last beat only:
  - r = acc + (round_en ? 2^(FRAC_BITS-1) : 0). This addition saturates at ACC_WIDTH.
  - r is arithmetically shifted right by FRAC_BITS.
  - If r > 2^(WIDTH-1)-1, out_sum = 0x7FFF (for WIDTH=16). If r < -2^(WIDTH-1), out_sum = 0x8000. Otherwise out_sum = r[WIDTH-1:0].
  - out_overflow = sticky | output clamp.
  - Accumulator and sticky flag clear in the same edge.
- Latency: with no stalls, a last beat accepted at edge N gives out_valid=1 after edge N+3. Throughput is one beat per cycle.
- A vector of one beat (in_last=1 on its only beat) is legal.
- Non-last beats produce no output.
- out_valid clears on out_ready unless a new result loads in the same edge, in which case out_valid stays 1.
- Beats with in_valid=0 insert bubbles; the accumulator keeps its value across bubbles.
- busy = any stage valid || accumulator non-empty || out_valid.

Optional Feature:
FIXED_MAC_RELU_EN: when defined, S3 applies ReLU after saturation: a negative result gives out_sum=0. out_overflow is unchanged; a negative clamp still reports 1. When undefined, out_sum is the signed saturated value. Latency is identical either way.

Test Plan:
- Single beat, a={0x0100,0x0200,0x0080,0xFF00}, b=all 0x0100, last=1 -> out_sum=0x0280, out_overflow=0, out_valid 3 cycles after accept.
- Three back-to-back beats, all lanes 0x0100*0x0100, last on beat 3 -> exactly one result 0x0C00, no output for beats 1-2.
- Saturation: one beat of a=b=0x7FFF on all lanes -> out_sum=0x7FFF, overflow=1. One beat of a=0x8000, b=0x7FFF on all lanes -> out_sum=0x8000, overflow=1.
- Rounding, lane0 0x0001*0x0080 with other lanes zero: round_en=0 -> 0x0000; round_en=1 -> 0x0001. Lane0 0xFFFF*0x0080 with round_en=0 -> 0xFFFF.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, out_sum stable for 10 cycles, no beat lost. Release -> queued results emerge in order.
- Reset after 2 beats of a vector -> outputs zero, busy=0. Next 1-beat vector 0x0100*0x0100 on lane0 -> 0x0100 with no stale accumulation.

Source files
------------

// File: rtl/fixed_mac_pipe.sv
// fixed_mac_pipe: pipelined saturating fixed-point multi-lane MAC with valid/ready (ports: clk, rst_n, in_valid/in_ready/in_a/in_b/in_last/round_en, out_valid/out_ready/out_sum/out_overflow, busy; optional FIXED_MAC_RELU_EN)
module fixed_mac_pipe #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_last,
  input  logic                   round_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_overflow,
  output logic                   busy
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OMAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OMIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] x, input logic signed [ACC_WIDTH-1:0] y);
    logic signed [ACC_WIDTH:0] s;
    logic ov;
    s  = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
    ov = s[ACC_WIDTH] != s[ACC_WIDTH-1];
    return {ov, ov ? (s[ACC_WIDTH] ? AMIN : AMAX) : s[ACC_WIDTH-1:0]};
  endfunction
  logic                        advance;
  logic                        v1, l1, rd1;
  logic signed [PW-1:0]        p1 [LANES];
  logic signed [ACC_WIDTH-1:0] acc, lane_sum, fin_acc, s3_q, nsum_v, r_v;
  logic                        acc_full, sticky, nsum_o, fin_v, fin_ovf, fin_rd, r_o;
  logic                        s3_v, s3_ovf, hi, lo;
  logic [WIDTH-1:0]            sat_v, res;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign busy     = v1 || acc_full || fin_v || s3_v || out_valid;
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + ACC_WIDTH'(p1[i]);
    {nsum_o, nsum_v} = sat_add(acc_full ? acc : '0, lane_sum);
    {r_o, r_v} = sat_add(fin_acc, fin_rd ? RND : '0);
    hi    = s3_q > OMAX;
    lo    = s3_q < OMIN;
    sat_v = hi ? {1'b0, {(WIDTH-1){1'b1}}} : lo ? {1'b1, {(WIDTH-1){1'b0}}} : s3_q[WIDTH-1:0];
`ifdef FIXED_MAC_RELU_EN
    res   = sat_v[WIDTH-1] ? '0 : sat_v;
`else
    res   = sat_v;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      rd1 <= 1'b0;
      for (int i = 0; i < LANES; i++) p1[i] <= '0;
      acc <= '0;
      acc_full <= 1'b0;
      sticky <= 1'b0;
      fin_v <= 1'b0;
      fin_acc <= '0;
      fin_ovf <= 1'b0;
      fin_rd <= 1'b0;
      s3_v <= 1'b0;
      s3_q <= '0;
      s3_ovf <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_overflow <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        l1  <= in_last;
        rd1 <= round_en;
        for (int i = 0; i < LANES; i++)
          p1[i] <= PW'($signed(in_a[i*WIDTH +: WIDTH])) * PW'($signed(in_b[i*WIDTH +: WIDTH]));
      end
      fin_v <= v1 && l1;
      if (v1 && l1) begin
        fin_acc  <= nsum_v;
        fin_ovf  <= sticky || nsum_o;
        fin_rd   <= rd1;
        acc_full <= 1'b0;
        sticky   <= 1'b0;
      end else if (v1) begin
        acc      <= nsum_v;
        acc_full <= 1'b1;
        sticky   <= sticky || nsum_o;
      end
      s3_v <= fin_v;
      if (fin_v) begin
        s3_q   <= r_v >>> FRAC_BITS;
        s3_ovf <= fin_ovf || r_o;
      end
      out_valid <= s3_v;
      if (s3_v) begin
        out_sum      <= res;
        out_overflow <= s3_ovf || hi || lo;
      end
    end
  end
endmodule
